gcd_stream_unit: RTL and testbench

- Streaming 4-bit greatest-common-divisor unit.
- Operands A and B each arrive through a single-entry input buffer with an enable/ready handshake.
- An iterative subtractive-Euclid engine computes the GCD.
- Results queue in a 2-entry output FIFO that the consumer drains with y_en.
- Sits between an operand producer and a result consumer; it is the computational core of the GCD interface wrapper.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_fifo.sv | 55 +++++
 rtl/gcd_stream_unit.sv | 88 ++++++++
 tb/tb_gcd_stream_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared constants, data type and engine state encoding for the GCD stream unit.
package gcd_pkg;
  localparam int DATA_W  = 4;
  localparam int Y_DEPTH = 2;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;
endpackage

// File: rtl/gcd_fifo.sv
// Parameterized synchronous circular FIFO; writes when full and reads when empty are ignored.
// data_o shows the head combinationally and reads as 0 when empty.
module gcd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign wr_ok   = wr_en && !full_o;
  assign rd_ok   = rd_en && !empty_o;
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/gcd_stream_unit.sv
// Streaming subtractive-Euclid GCD: single-entry operand buffers, iterative engine, result FIFO.
//   state | meaning
//   IDLE  | waiting for both operands and a free result slot
//   CALC  | one subtraction per cycle until equal or a zero appears
//   DONE  | result latched; flags a one-cycle valid that pushes it next cycle
module gcd_stream_unit
  import gcd_pkg::*;
#(
  parameter int DATA_W  = gcd_pkg::DATA_W,
  parameter int Y_DEPTH = gcd_pkg::Y_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_en,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_en,
  input  logic              y_en,
  output logic              a_rdy,
  output logic              b_rdy,
  output logic [DATA_W-1:0] y_data,
  output logic              y_rdy
);
  gcd_state_e        state, state_nxt;
  logic [DATA_W-1:0] a_reg, b_reg, res_reg;
  logic [DATA_W-1:0] a_buf, b_buf;
  logic              a_full, b_full, a_empty, b_empty;
  logic              y_full, y_empty;
  logic              res_valid;
  logic              start, finish;

  gcd_fifo #(.DEPTH(1), .WIDTH(DATA_W)) u_a_buf (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en(a_en && a_rdy), .rd_en(start),
    .data_i(a_data), .data_o(a_buf), .full_o(a_full), .empty_o(a_empty)
  );

  gcd_fifo #(.DEPTH(1), .WIDTH(DATA_W)) u_b_buf (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en(b_en && b_rdy), .rd_en(start),
    .data_i(b_data), .data_o(b_buf), .full_o(b_full), .empty_o(b_empty)
  );

  gcd_fifo #(.DEPTH(Y_DEPTH), .WIDTH(DATA_W)) u_y_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en(res_valid), .rd_en(y_en),
    .data_i(res_reg), .data_o(y_data), .full_o(y_full), .empty_o(y_empty)
  );

  assign a_rdy = a_empty;
  assign b_rdy = b_empty;
  assign y_rdy = !y_empty;

  // A pending push still occupies a slot, so hold off a new start until it lands.
  assign start  = (state == IDLE) && a_full && b_full && !y_full && !res_valid;
  assign finish = (a_reg == b_reg) || (a_reg == '0) || (b_reg == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= (state == DONE);
      if (start) begin
        a_reg <= a_buf;
        b_reg <= b_buf;
      end else if (state == CALC) begin
        if (finish)             res_reg <= (a_reg == '0) ? b_reg : a_reg;
        else if (a_reg > b_reg) a_reg   <= a_reg - b_reg;
        else                    b_reg   <= b_reg - a_reg;
      end
    end
  end
endmodule

// File: tb/tb_gcd_stream_unit.sv
// Self-checking bench for gcd_stream_unit: vector table, hand-written corner sequences,
// and random pairs checked against a modulo-Euclid reference model.
module tb_gcd_stream_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a_data = '0, b_data = '0;
  logic       a_en = 1'b0, b_en = 1'b0, y_en = 1'b0;
  logic       a_rdy, b_rdy, y_rdy;
  logic [3:0] y_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_y;
    int         exp_subs;
  } vec_t;

  vec_t vecs [6];

  gcd_stream_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_data(a_data), .a_en(a_en),
    .b_data(b_data), .b_en(b_en),
    .y_en(y_en),
    .a_rdy(a_rdy), .b_rdy(b_rdy),
    .y_data(y_data), .y_rdy(y_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // gcd by remainders; subtractive step count is the sum of quotients minus one.
  task automatic ref_gcd(input int a, input int b, output int g, output int subs);
    int x, y, q, r;
    if (a == 0 || b == 0) begin
      g = a + b;
      subs = 0;
    end else begin
      x = a; y = b; q = 0;
      while (y != 0) begin
        q += x / y;
        r = x % y;
        x = y;
        y = r;
      end
      g = x;
      subs = q - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!(a_rdy && b_rdy) && n < 60) begin
      tick();
      n++;
    end
    if (!(a_rdy && b_rdy)) check({name, " rdy timeout"}, 0, 1);
  endtask

  task automatic write_pair(input logic [3:0] a, input logic [3:0] b);
    a_data = a; b_data = b; a_en = 1'b1; b_en = 1'b1;
    tick();
    a_en = 1'b0; b_en = 1'b0;
  endtask

  task automatic pop();
    y_en = 1'b1;
    tick();
    y_en = 1'b0;
  endtask

  task automatic run_pair(input string name, input logic [3:0] a, input logic [3:0] b,
                          input int exp_y, input int exp_subs);
    int k = 0;
    wait_rdy(name);
    write_pair(a, b);
    while (!y_rdy && k < 40) begin
      tick();
      k++;
    end
    // k counts edges after the write edge; the load edge is the first of them.
    check({name, " latency"}, k, exp_subs + 4);
    check({name, " y_data"}, y_data, exp_y);
    pop();
    check({name, " empty after pop"}, y_rdy, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " a_rdy"}, a_rdy, 1);
    check({name, " b_rdy"}, b_rdy, 1);
    check({name, " y_rdy"}, y_rdy, 0);
    check({name, " y_data"}, y_data, 0);
  endtask

  initial begin
    int g, s, ra, rb, k;
    vecs[0] = '{4'd12, 4'd8,  4'd4, 2};
    vecs[1] = '{4'd0,  4'd9,  4'd9, 0};
    vecs[2] = '{4'd7,  4'd0,  4'd7, 0};
    vecs[3] = '{4'd0,  4'd0,  4'd0, 0};
    vecs[4] = '{4'd5,  4'd5,  4'd5, 0};
    vecs[5] = '{4'd15, 4'd1,  4'd1, 14};

    #12 check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) tick();
    check_reset_outputs("idle");

    for (int i = 0; i < 6; i++)
      run_pair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_y, vecs[i].exp_subs);

    // A second write to a full A buffer is dropped.
    wait_rdy("drop");
    a_data = 4'd6; a_en = 1'b1;
    tick();
    check("drop a_rdy low", a_rdy, 0);
    a_data = 4'd3;
    tick();
    a_en = 1'b0;
    b_data = 4'd4; b_en = 1'b1;
    tick();
    b_en = 1'b0;
    k = 0;
    while (!y_rdy && k < 40) begin tick(); k++; end
    check("drop y_rdy", y_rdy, 1);
    check("drop result", y_data, 2);
    pop();

    // Backpressure: two results fill the FIFO, the third pair waits in the buffers.
    wait_rdy("bp1");
    write_pair(4'd15, 4'd5);
    wait_rdy("bp2");
    write_pair(4'd9, 4'd6);
    wait_rdy("bp3");
    write_pair(4'd8, 4'd4);
    repeat (25) tick();
    check("bp head", y_data, 5);
    check("bp a_rdy held", a_rdy, 0);
    check("bp b_rdy held", b_rdy, 0);
    pop();
    check("bp second", y_data, 3);
    repeat (20) tick();
    check("bp third released", a_rdy && b_rdy, 1);
    pop();
    check("bp third", y_data, 4);
    pop();
    check("bp drained", y_rdy, 0);

    // Random pairs against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      ref_gcd(ra, rb, g, s);
      run_pair($sformatf("rnd(%0d,%0d)", ra, rb), 4'(ra), 4'(rb), g, s);
    end

    // Reset during CALC aborts the computation.
    wait_rdy("midrst");
    write_pair(4'd15, 4'd1);
    repeat (5) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) tick();
    check("midrst no result", y_rdy, 0);
    check("midrst a_rdy", a_rdy, 1);

    run_pair("post_reset", 4'd12, 4'd8, 4, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
